i2c_bus_conditioner: RTL and testbench

//  Front-end stage between the board-level I2C pads (io_i2c_scl/io_i2c_sda) and the I2C slave core.

---
 rtl/i2c_bus_conditioner.sv | 151 +++++++++++++++
 tb/tb_i2c_bus_conditioner.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_conditioner.sv
// I2C pad front-end: synchronises and deglitches SCL/SDA, emits edge and START/STOP pulses,
// and tracks bus ownership with an SCL-stuck-low timeout.
module i2c_bus_conditioner #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 3,
  parameter int unsigned TIMEOUT_W      = 21,
  parameter int unsigned TIMEOUT_CYCLES = 1_250_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_scl,
  input  logic       i_sda,
  input  logic       i_enable,
  input  logic       i_clr_timeout,
  output logic       o_scl,
  output logic       o_sda,
  output logic       o_scl_rise,
  output logic       o_scl_fall,
  output logic       o_start,
  output logic       o_rstart,
  output logic       o_stop,
  output logic       o_busy,
  output logic       o_timeout,
  output logic [7:0] o_glitch_cnt
);

  localparam int unsigned FCNT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
  localparam logic [FCNT_W-1:0]    FILT_LAST = FCNT_W'(FILTER_LEN - 1);
  localparam logic [TIMEOUT_W-1:0] TO_MAX    = TIMEOUT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StBusy, StTimeout} state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic [1:0]             synced;         // [1] = SCL, [0] = SDA
  logic [1:0]             filt_q, filt_d;
  logic [1:0]             glitch;
  logic [FCNT_W-1:0]      fcnt_q [2];
  logic [FCNT_W-1:0]      fcnt_d [2];
  logic [8:0]             glitch_sum;
  logic [TIMEOUT_W-1:0]   to_cnt_q;
  logic                   start_det, stop_det;
  state_e                 state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i_scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], i_sda};
    end
  end

  assign synced = {scl_sync_q[SYNC_STAGES-1], sda_sync_q[SYNC_STAGES-1]};

  // A new level is accepted on its FILTER_LEN-th consecutive cycle; an early return is a glitch.
  always_comb begin
    filt_d = filt_q;
    glitch = '0;
    for (int i = 0; i < 2; i++) begin
      fcnt_d[i] = '0;
      if (synced[i] != filt_q[i]) begin
        if (fcnt_q[i] == FILT_LAST) filt_d[i] = synced[i];
        else                        fcnt_d[i] = fcnt_q[i] + FCNT_W'(1);
      end else if (fcnt_q[i] != '0) begin
        glitch[i] = 1'b1;
      end
    end
  end

  assign glitch_sum = {1'b0, o_glitch_cnt} + 9'(glitch[1]) + 9'(glitch[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q       <= 2'b11;
      fcnt_q[0]    <= '0;
      fcnt_q[1]    <= '0;
      o_scl_rise   <= 1'b0;
      o_scl_fall   <= 1'b0;
      o_glitch_cnt <= '0;
    end else begin
      filt_q     <= filt_d;
      fcnt_q[0]  <= fcnt_d[0];
      fcnt_q[1]  <= fcnt_d[1];
      o_scl_rise <= filt_d[1] & ~filt_q[1];
      o_scl_fall <= ~filt_d[1] & filt_q[1];
      if (!i_enable)          o_glitch_cnt <= '0;
      else if (glitch_sum[8]) o_glitch_cnt <= 8'hff;
      else                    o_glitch_cnt <= glitch_sum[7:0];
    end
  end

  assign o_scl = filt_q[1];
  assign o_sda = filt_q[0];

  // SCL must be high and stable across the SDA change for either condition.
  assign start_det = filt_q[1] & filt_d[1] & filt_q[0] & ~filt_d[0];
  assign stop_det  = filt_q[1] & filt_d[1] & ~filt_q[0] & filt_d[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      to_cnt_q  <= '0;
      o_start   <= 1'b0;
      o_rstart  <= 1'b0;
      o_stop    <= 1'b0;
      o_busy    <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      o_start   <= 1'b0;
      o_rstart  <= 1'b0;
      o_stop    <= 1'b0;
      o_busy    <= (state_q == StBusy);
      o_timeout <= (state_q == StTimeout);
      if (!i_enable) begin
        state_q  <= StIdle;
        to_cnt_q <= '0;
      end else begin
        if (state_q == StBusy && !filt_q[1]) begin
          if (to_cnt_q != TO_MAX) to_cnt_q <= to_cnt_q + TIMEOUT_W'(1);
        end else begin
          to_cnt_q <= '0;
        end
        o_stop <= stop_det;
        case (state_q)
          StIdle: begin
            if (start_det) begin
              state_q <= StBusy;
              o_start <= 1'b1;
            end
          end
          StBusy: begin
            if (start_det)               o_rstart <= 1'b1;
            else if (stop_det)           state_q  <= StIdle;
            else if (to_cnt_q == TO_MAX) state_q  <= StTimeout;
          end
          StTimeout: begin
            if (start_det) begin
              state_q <= StBusy;
              o_start <= 1'b1;
            end else if (stop_det || i_clr_timeout) begin
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// Bench for i2c_bus_conditioner: a small bus model predicts event pulses into a queue that a
// negedge monitor pops and compares; each scenario task also checks levels inline.
module tb_i2c_bus_conditioner;

  localparam logic [4:0] EV_RISE   = 5'b10000;
  localparam logic [4:0] EV_FALL   = 5'b01000;
  localparam logic [4:0] EV_START  = 5'b00100;
  localparam logic [4:0] EV_RSTART = 5'b00010;
  localparam logic [4:0] EV_STOP   = 5'b00001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_scl = 1'b1, i_sda = 1'b1, i_enable = 1'b1, i_clr_timeout = 1'b0;
  logic       o_scl, o_sda, o_scl_rise, o_scl_fall, o_start, o_rstart, o_stop;
  logic       o_busy, o_timeout;
  logic [7:0] o_glitch_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int rise_cnt = 0;
  logic [4:0] exp_q [$];
  logic m_scl = 1'b1, m_sda = 1'b1, m_busy = 1'b0;

  always #5 clk = ~clk;

  i2c_bus_conditioner #(
    .SYNC_STAGES(2), .FILTER_LEN(3), .TIMEOUT_W(21), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst(rst), .i_scl(i_scl), .i_sda(i_sda), .i_enable(i_enable),
    .i_clr_timeout(i_clr_timeout), .o_scl(o_scl), .o_sda(o_sda), .o_scl_rise(o_scl_rise),
    .o_scl_fall(o_scl_fall), .o_start(o_start), .o_rstart(o_rstart), .o_stop(o_stop),
    .o_busy(o_busy), .o_timeout(o_timeout), .o_glitch_cnt(o_glitch_cnt)
  );

  // Monitor: every pulse cycle must match the next predicted event.
  always @(negedge clk) begin
    logic [4:0] obs, expv;
    if (!rst) begin
      obs = {o_scl_rise, o_scl_fall, o_start, o_rstart, o_stop};
      if (o_scl_rise) rise_cnt++;
      if (obs != 5'b0) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL event_unexpected got=%b required=none", obs);
        end else begin
          expv = exp_q.pop_front();
          if (obs !== expv) begin
            n_fail++;
            $display("FAIL event_order got=%b required=%b", obs, expv);
          end
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive pads and predict the filtered-domain event they must produce.
  task automatic drive(input logic scl, input logic sda);
    logic [4:0] ev;
    ev = '0;
    if (scl != m_scl) begin
      ev = scl ? EV_RISE : EV_FALL;
    end else if (sda != m_sda && m_scl) begin
      if (!sda) begin
        ev = m_busy ? EV_RSTART : EV_START;
        m_busy = 1'b1;
      end else begin
        ev = EV_STOP;
        m_busy = 1'b0;
      end
    end
    if (ev != 5'b0) exp_q.push_back(ev);
    m_scl = scl;
    m_sda = sda;
    i_scl = scl;
    i_sda = sda;
  endtask

  task automatic test_reset();
    wait_cyc(2);
    n_checks++;
    if ({o_scl, o_sda, o_scl_rise, o_scl_fall, o_start, o_rstart, o_stop, o_busy, o_timeout,
         o_glitch_cnt} !== {2'b11, 7'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_held got=%b%b busy=%b to=%b g=%0d required=11 0 0 0", o_scl, o_sda,
               o_busy, o_timeout, o_glitch_cnt);
    end
    rst = 1'b0;
    wait_cyc(4);
    n_checks++;
    if ({o_scl, o_sda, o_busy, o_timeout, o_glitch_cnt} !== {2'b11, 2'b00, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_release got=%b%b busy=%b to=%b g=%0d required=11 0 0 0", o_scl, o_sda,
               o_busy, o_timeout, o_glitch_cnt);
    end
  endtask

  task automatic test_start();
    drive(1'b1, 1'b0);
    wait_cyc(4);
    n_checks++;
    if (o_start !== 1'b0) begin
      n_fail++;
      $display("FAIL start_early got=%b required=0", o_start);
    end
    wait_cyc(1);
    n_checks++;
    if ({o_start, o_sda, o_busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL start_latency got=%b required=100", {o_start, o_sda, o_busy});
    end
    wait_cyc(1);
    n_checks++;
    if ({o_start, o_busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL start_busy got=%b required=01", {o_start, o_busy});
    end
    drive(1'b0, 1'b0);
    wait_cyc(5);
    n_checks++;
    if ({o_scl_fall, o_scl} !== 2'b10) begin
      n_fail++;
      $display("FAIL scl_fall_latency got=%b required=10", {o_scl_fall, o_scl});
    end
    wait_cyc(3);
  endtask

  task automatic test_byte_rstart();
    logic [8:0] bits;
    int r0;
    bits = {8'hA5, 1'b0};
    r0 = rise_cnt;
    for (int i = 8; i >= 0; i--) begin
      drive(1'b0, bits[i]);
      wait_cyc(8);
      drive(1'b1, bits[i]);
      wait_cyc(8);
      drive(1'b0, bits[i]);
      wait_cyc(8);
    end
    n_checks++;
    if (rise_cnt - r0 != 9) begin
      n_fail++;
      $display("FAIL byte_rise_count got=%0d required=9", rise_cnt - r0);
    end
    drive(1'b0, 1'b1);
    wait_cyc(8);
    drive(1'b1, 1'b1);
    wait_cyc(8);
    drive(1'b1, 1'b0);
    wait_cyc(8);
    n_checks++;
    if ({o_busy, o_timeout} !== 2'b10) begin
      n_fail++;
      $display("FAIL rstart_busy got=%b required=10", {o_busy, o_timeout});
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL byte_missing_events got=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_stop();
    drive(1'b1, 1'b1);
    wait_cyc(8);
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_busy got=%b required=0", o_busy);
    end
    drive(1'b0, 1'b1);
    wait_cyc(8);
    drive(1'b0, 1'b0);
    wait_cyc(8);
    drive(1'b1, 1'b0);
    wait_cyc(8);
    drive(1'b1, 1'b1);
    wait_cyc(8);
    n_checks++;
    if ({o_busy, o_timeout} !== 2'b00 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stop_idle got=%b pending=%0d required=00 pending=0", {o_busy, o_timeout},
               exp_q.size());
    end
  endtask

  task automatic test_glitch();
    logic saw_low;
    saw_low = 1'b0;
    i_scl = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) i_scl = 1'b1;
      @(negedge clk);
      saw_low |= ~o_scl;
    end
    n_checks++;
    if ({saw_low, o_glitch_cnt} !== {1'b0, 8'd1}) begin
      n_fail++;
      $display("FAIL glitch_single got=low%b cnt%0d required=low0 cnt1", saw_low, o_glitch_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      i_scl = 1'b0;
      i_sda = 1'b0;
      wait_cyc(2);
      i_scl = 1'b1;
      i_sda = 1'b1;
      wait_cyc(4);
    end
    n_checks++;
    if (o_glitch_cnt !== 8'd9) begin
      n_fail++;
      $display("FAIL glitch_double got=%0d required=9", o_glitch_cnt);
    end
    for (int i = 0; i < 300; i++) begin
      i_scl = 1'b0;
      wait_cyc(2);
      i_scl = 1'b1;
      wait_cyc(3);
    end
    wait_cyc(4);
    n_checks++;
    if ({o_scl, o_glitch_cnt} !== {1'b1, 8'd255}) begin
      n_fail++;
      $display("FAIL glitch_saturate got=scl%b cnt%0d required=scl1 cnt255", o_scl, o_glitch_cnt);
    end
  endtask

  task automatic test_timeout();
    drive(1'b1, 1'b0);
    wait_cyc(8);
    drive(1'b0, 1'b0);
    wait_cyc(100);
    drive(1'b1, 1'b0);
    wait_cyc(8);
    m_busy = 1'b0;
    n_checks++;
    if ({o_timeout, o_busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL timeout_100 got=%b required=10", {o_timeout, o_busy});
    end
    i_clr_timeout = 1'b1;
    wait_cyc(1);
    i_clr_timeout = 1'b0;
    wait_cyc(2);
    n_checks++;
    if ({o_timeout, o_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL timeout_clear got=%b required=00", {o_timeout, o_busy});
    end
    drive(1'b1, 1'b1);
    wait_cyc(8);
    drive(1'b1, 1'b0);
    wait_cyc(8);
    drive(1'b0, 1'b0);
    wait_cyc(99);
    drive(1'b1, 1'b0);
    wait_cyc(8);
    n_checks++;
    if ({o_timeout, o_busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL timeout_99 got=%b required=01", {o_timeout, o_busy});
    end
    drive(1'b0, 1'b0);
    wait_cyc(2);
    drive(1'b0, 1'b1);
    wait_cyc(118);
    drive(1'b1, 1'b1);
    wait_cyc(8);
    m_busy = 1'b0;
    n_checks++;
    if ({o_timeout, o_busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL timeout_again got=%b required=10", {o_timeout, o_busy});
    end
    drive(1'b1, 1'b0);
    wait_cyc(8);
    n_checks++;
    if ({o_timeout, o_busy} !== 2'b01 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL timeout_start got=%b pending=%0d required=01 pending=0", {o_timeout, o_busy},
               exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b0);
    wait_cyc(8);
    drive(1'b1, 1'b0);
    wait_cyc(8);
    drive(1'b0, 1'b0);
    wait_cyc(8);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({o_scl, o_sda, o_scl_rise, o_scl_fall, o_start, o_rstart, o_stop, o_busy, o_timeout,
         o_glitch_cnt} !== {2'b11, 7'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL async_reset got=%b%b busy=%b to=%b g=%0d required=11 0 0 0", o_scl, o_sda,
               o_busy, o_timeout, o_glitch_cnt);
    end
    wait_cyc(3);
    rst = 1'b0;
    m_scl = 1'b1;
    m_sda = 1'b1;
    m_busy = 1'b0;
    drive(1'b0, 1'b0);
    wait_cyc(8);
    n_checks++;
    if ({o_scl, o_sda, o_busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL post_reset_levels got=%b required=000", {o_scl, o_sda, o_busy});
    end
    drive(1'b1, 1'b0);
    wait_cyc(8);
    drive(1'b0, 1'b0);
    wait_cyc(8);
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle got=%b required=0", o_busy);
    end
    drive(1'b1, 1'b0);
    wait_cyc(8);
    drive(1'b1, 1'b1);
    wait_cyc(8);
    drive(1'b1, 1'b0);
    wait_cyc(8);
    n_checks++;
    if (o_busy !== 1'b1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL fresh_start got=%b pending=%0d required=1 pending=0", o_busy, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_byte_rstart();
    test_stop();
    test_glitch();
    test_timeout();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
